cpu_execute_mc: RTL and testbench
=================================

Name: cpu_execute_mc

Overview:
Parametrised, multi-cycle successor to the moxie execute stage. Sits between decode and write-back. Executes ALU, compare, immediate-load, multiply and divide/modulo ops. Division is iterative; a busy/accept handshake stalls decode while the divider runs, and a registered compare-flag word feeds the branch logic.

Parameters:
DATA_WIDTH, 32, operand/result width; must be even and at least 8.
RIDX_WIDTH, 4, register index width.
OP_WIDTH, 6, opcode width; opcodes are the `OP_* values from defines.v.
DIV_ENABLE, 1, 1 = iterative divider present; 0 = DIV/MOD ops complete in 1 cycle with result 0 and div_zero_o=0.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
valid_i  in  1  decode presents an instruction this cycle
stall_i  in  1  downstream stall; no result may be issued while high
op_i  in  OP_WIDTH  opcode
regA_i  in  DATA_WIDTH  operand A (rA value)
regB_i  in  DATA_WIDTH  operand B (rB value)
operand_i  in  DATA_WIDTH  immediate/literal
register_write_index_i  in  RIDX_WIDTH  destination register
busy_o  out  1  high = instruction not accepted this cycle; decode must hold
register_write_enable_o  out  1  one-cycle write strobe
register_write_index_o  out  RIDX_WIDTH  destination of result_o
result_o  out  DATA_WIDTH  result
flags_o  out  5  {gtu,gt,ltu,lt,eq} from last CMP
div_zero_o  out  1  one-cycle pulse coincident with the write strobe of a divide/mod by zero

Behaviour:
- Reset (async, active-high): all outputs 0; FSM to IDLE; any divide in flight is discarded with no write.
- Accept: valid_i & ~busy_o & ~stall_i at a clock edge. busy_o = stall_i | (state != IDLE), combinational.
- Single-cycle ops, result registered at the next edge, write enable 1:
  - ADD_L = A+B; SUB_L = A-B; AND, OR, XOR on A,B; NOT = ~B; NEG = -B.
  - ASHL = A<<B[log2(DATA_WIDTH)-1:0]; LSHR is logical; ASHR is arithmetic.
  - INC = A+imm; DEC = A-imm; LDI_L = imm; MOV = B.
  - MUL_L = low DATA_WIDTH bits of A*B.
  - All arithmetic wraps modulo 2^DATA_WIDTH.
- CMP: flags_o updated at the next edge (eq=A==B, lt signed, ltu unsigned, gt, gtu); write enable 0.
- NOP, unlisted opcodes, cycles with no accept: write enable 0, result_o/index hold, flags hold.
- Divider FSM (DIV_ENABLE=1), for DIV_L/UDIV_L/MOD_L/UMOD_L:
  - IDLE -> RUN on accept. Operands are latched; signed ops use magnitudes plus sign bits.
  - RUN: one restoring quotient bit per cycle, DATA_WIDTH cycles.
  - RUN -> DONE after the last bit. DONE applies the sign fix-up (quotient sign = sA^sB, remainder sign = sA).
  - DONE -> IDLE on the first edge with stall_i low; that edge asserts the write, so the result is registered and visible the following cycle.
  - Latency from accept to write strobe is DATA_WIDTH+1 cycles with no stall.
  - stall_i during RUN does not pause iteration; in DONE it holds the result.
- Divide by zero: quotient = all ones, remainder = dividend, div_zero_o pulses with the write. The divider still takes full latency.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0, no div_zero_o.
- stall_i high with no divide completing: write enable 0 next cycle (as today's stage).
- valid_i while busy_o is ignored; decode re-presents the instruction.

Test Plan:
- Reset mid-divide: UDIV_L 100/7 accepted, assert rst_i on cycle 5 -> all outputs 0 immediately, no write strobe afterwards, next ADD_L accepted at once.
- Single-cycle ALU: ADD_L 0xFFFFFFFF+2 -> result 0x1 to rd; ASHR 0x80000000 by 4 -> 0xF8000000; LDI_L 0x12345678 -> same; each with write enable high exactly 1 cycle after accept.
- CMP signed/unsigned: A=0xFFFFFFFF, B=1 -> flags_o=5'b10010 (gtu, lt), no write; then NOP -> flags unchanged.
- Signed divide: DIV_L -7/2 -> quotient 0xFFFFFFFD, write at accept+33, busy_o high for cycles 1..32; MOD_L -7/2 -> 0xFFFFFFFF.
- Divide by zero and overflow: UDIV_L 5/0 -> 0xFFFFFFFF with div_zero_o pulse; DIV_L 0x80000000/-1 -> 0x80000000, no pulse.
- Stall interaction: stall_i high from DIV cycle 30 to 40 -> write occurs on the first edge after stall_i falls with the correct result; valid_i with ADD during stall is not accepted.

Source files
------------

// File: rtl/cpu_execute_mc.sv
// Multi-cycle execute stage: single-cycle ALU/compare/multiply ops plus an
// iterative restoring divider that holds decode off through busy_o.

module cpu_execute_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int RIDX_WIDTH = 4,
    parameter int OP_WIDTH   = 6,
    parameter int DIV_ENABLE = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  stall_i,
    input  logic [OP_WIDTH-1:0]   op_i,
    input  logic [DATA_WIDTH-1:0] regA_i,
    input  logic [DATA_WIDTH-1:0] regB_i,
    input  logic [DATA_WIDTH-1:0] operand_i,
    input  logic [RIDX_WIDTH-1:0] register_write_index_i,
    output logic                  busy_o,
    output logic                  register_write_enable_o,
    output logic [RIDX_WIDTH-1:0] register_write_index_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [4:0]            flags_o,
    output logic                  div_zero_o
);

    localparam int SH_W  = $clog2(DATA_WIDTH);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [OP_WIDTH-1:0] OP_NOP    = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_ADD_L  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_SUB_L  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_AND    = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_OR     = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_XOR    = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_NOT    = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_NEG    = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_ASHL   = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_LSHR   = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_ASHR   = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] OP_INC    = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_DEC    = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] OP_LDI_L  = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] OP_MOV    = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] OP_MUL_L  = OP_WIDTH'(15);
    localparam logic [OP_WIDTH-1:0] OP_CMP    = OP_WIDTH'(16);
    localparam logic [OP_WIDTH-1:0] OP_DIV_L  = OP_WIDTH'(17);
    localparam logic [OP_WIDTH-1:0] OP_UDIV_L = OP_WIDTH'(18);
    localparam logic [OP_WIDTH-1:0] OP_MOD_L  = OP_WIDTH'(19);
    localparam logic [OP_WIDTH-1:0] OP_UMOD_L = OP_WIDTH'(20);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    // Architectural output registers
    logic                  we_q, we_d;
    logic [RIDX_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [4:0]            flags_q, flags_d;
    logic                  dz_out_q, dz_out_d;

    // Divider working registers
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sa_q, sa_d;
    logic                  sb_q, sb_d;
    logic                  mod_q, mod_d;
    logic                  dz_q, dz_d;
    logic [RIDX_WIDTH-1:0] div_rd_q, div_rd_d;

    logic                  accept;
    logic                  start_div;
    logic                  is_div;
    logic                  div_signed;
    logic                  div_mod;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_we;
    logic                  cmp_upd;
    logic [4:0]            cmp_flags;
    logic [SH_W-1:0]       shamt;
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH:0]   diff;
    logic                  qbit;
    logic [DATA_WIDTH-1:0] quo_fix;
    logic [DATA_WIDTH-1:0] rem_fix;

    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v,
                                                        input logic              sgn);
        return (sgn && v[DATA_WIDTH-1]) ? -v : v;
    endfunction

    assign accept    = valid_i & ~busy_o & ~stall_i;
    assign start_div = accept & is_div & (DIV_ENABLE != 0);
    assign shamt     = regB_i[SH_W-1:0];

    assign cmp_flags = {regA_i > regB_i,
                        $signed(regA_i) > $signed(regB_i),
                        regA_i < regB_i,
                        $signed(regA_i) < $signed(regB_i),
                        regA_i == regB_i};

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    assign trial = {rem_q, quo_q[DATA_WIDTH-1]};
    assign diff  = trial - {1'b0, dsr_q};
    assign qbit  = ~diff[DATA_WIDTH];

    always_comb begin
        quo_fix = (sa_q ^ sb_q) ? -quo_q : quo_q;
        if (dz_q) begin
            quo_fix = '1;
        end
        rem_fix = sa_q ? -rem_q : rem_q;
    end

    always_comb begin
        is_div     = 1'b0;
        div_signed = 1'b0;
        div_mod    = 1'b0;
        case (op_i)
            OP_DIV_L:  begin is_div = 1'b1; div_signed = 1'b1; end
            OP_UDIV_L: begin is_div = 1'b1; end
            OP_MOD_L:  begin is_div = 1'b1; div_signed = 1'b1; div_mod = 1'b1; end
            OP_UMOD_L: begin is_div = 1'b1; div_mod = 1'b1; end
            default:   ;
        endcase
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_res = '0;
        alu_we  = 1'b1;
        cmp_upd = 1'b0;
        case (op_i)
            OP_ADD_L:  alu_res = regA_i + regB_i;
            OP_SUB_L:  alu_res = regA_i - regB_i;
            OP_AND:    alu_res = regA_i & regB_i;
            OP_OR:     alu_res = regA_i | regB_i;
            OP_XOR:    alu_res = regA_i ^ regB_i;
            OP_NOT:    alu_res = ~regB_i;
            OP_NEG:    alu_res = -regB_i;
            OP_ASHL:   alu_res = regA_i << shamt;
            OP_LSHR:   alu_res = regA_i >> shamt;
            OP_ASHR:   alu_res = $signed(regA_i) >>> shamt;
            OP_INC:    alu_res = regA_i + operand_i;
            OP_DEC:    alu_res = regA_i - operand_i;
            OP_LDI_L:  alu_res = operand_i;
            OP_MOV:    alu_res = regB_i;
            OP_MUL_L:  alu_res = regA_i * regB_i;
            OP_CMP: begin
                alu_we  = 1'b0;
                cmp_upd = 1'b1;
            end
            // Without a divider these complete at once with a zero result.
            OP_DIV_L, OP_UDIV_L, OP_MOD_L, OP_UMOD_L: alu_res = '0;
            default:   alu_we = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_div) state_d = S_RUN;
            S_RUN:  if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = S_DONE;
            S_DONE: if (!stall_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = stall_i | (state_q != S_IDLE);
    end

    always_comb begin
        quo_d    = quo_q;
        rem_d    = rem_q;
        dsr_d    = dsr_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        mod_d    = mod_q;
        dz_d     = dz_q;
        div_rd_d = div_rd_q;
        if (start_div) begin
            quo_d    = magnitude(regA_i, div_signed);
            dsr_d    = magnitude(regB_i, div_signed);
            rem_d    = '0;
            cnt_d    = '0;
            sa_d     = div_signed & regA_i[DATA_WIDTH-1];
            sb_d     = div_signed & regB_i[DATA_WIDTH-1];
            mod_d    = div_mod;
            dz_d     = (regB_i == '0);
            div_rd_d = register_write_index_i;
        end else if (state_q == S_RUN) begin
            rem_d = qbit ? diff[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
            quo_d = {quo_q[DATA_WIDTH-2:0], qbit};
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        we_d     = 1'b0;
        dz_out_d = 1'b0;
        idx_d    = idx_q;
        res_d    = res_q;
        flags_d  = flags_q;
        if (state_q == S_DONE && !stall_i) begin
            we_d     = 1'b1;
            dz_out_d = dz_q;
            idx_d    = div_rd_q;
            res_d    = mod_q ? rem_fix : quo_fix;
        end else if (accept && !start_div) begin
            if (alu_we) begin
                we_d  = 1'b1;
                idx_d = register_write_index_i;
                res_d = alu_res;
            end
            if (cmp_upd) begin
                flags_d = cmp_flags;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q     <= 1'b0;
            idx_q    <= '0;
            res_q    <= '0;
            flags_q  <= '0;
            dz_out_q <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            mod_q    <= 1'b0;
            dz_q     <= 1'b0;
            div_rd_q <= '0;
        end else begin
            we_q     <= we_d;
            idx_q    <= idx_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            dz_out_q <= dz_out_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dsr_q    <= dsr_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            mod_q    <= mod_d;
            dz_q     <= dz_d;
            div_rd_q <= div_rd_d;
        end
    end

    assign register_write_enable_o = we_q;
    assign register_write_index_o  = idx_q;
    assign result_o                = res_q;
    assign flags_o                 = flags_q;
    assign div_zero_o              = dz_out_q;

endmodule

// File: tb/tb_cpu_execute_mc.sv
// Bench for cpu_execute_mc: directed test-plan sequences plus random traffic,
// all compared every cycle against a transaction-level model.

module tb_cpu_execute_mc;

    localparam int DW = 32;

    localparam int OP_NOP = 0, OP_ADD_L = 1, OP_SUB_L = 2, OP_AND = 3, OP_OR = 4,
                   OP_XOR = 5, OP_NOT = 6, OP_NEG = 7, OP_ASHL = 8, OP_LSHR = 9,
                   OP_ASHR = 10, OP_INC = 11, OP_DEC = 12, OP_LDI_L = 13, OP_MOV = 14,
                   OP_MUL_L = 15, OP_CMP = 16, OP_DIV_L = 17, OP_UDIV_L = 18,
                   OP_MOD_L = 19, OP_UMOD_L = 20;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          stall_i;
    logic [5:0]    op_i;
    logic [DW-1:0] regA_i;
    logic [DW-1:0] regB_i;
    logic [DW-1:0] operand_i;
    logic [3:0]    register_write_index_i;
    logic          busy_o;
    logic          register_write_enable_o;
    logic [3:0]    register_write_index_o;
    logic [DW-1:0] result_o;
    logic [4:0]    flags_o;
    logic          div_zero_o;

    always #5 clk_i = ~clk_i;

    cpu_execute_mc #(
        .DATA_WIDTH(DW),
        .RIDX_WIDTH(4),
        .OP_WIDTH  (6),
        .DIV_ENABLE(1)
    ) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .valid_i                (valid_i),
        .stall_i                (stall_i),
        .op_i                   (op_i),
        .regA_i                 (regA_i),
        .regB_i                 (regB_i),
        .operand_i              (operand_i),
        .register_write_index_i (register_write_index_i),
        .busy_o                 (busy_o),
        .register_write_enable_o(register_write_enable_o),
        .register_write_index_o (register_write_index_o),
        .result_o               (result_o),
        .flags_o                (flags_o),
        .div_zero_o             (div_zero_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level model: what the outputs must show after the last edge.
    bit          m_we;
    bit          m_dz;
    bit [3:0]    m_idx;
    bit [DW-1:0] m_res;
    bit [4:0]    m_flags;
    bit          m_pending;
    int          m_left;
    bit [DW-1:0] m_div_res;
    bit          m_div_dz;
    bit [3:0]    m_div_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_we = 0; m_dz = 0; m_idx = 0; m_res = 0; m_flags = 0;
        m_pending = 0; m_left = 0; m_div_res = 0; m_div_dz = 0; m_div_rd = 0;
    endtask

    function automatic bit [DW-1:0] ref_div(input int op, input bit [DW-1:0] a,
                                            input bit [DW-1:0] b);
        bit [DW-1:0] q, r;
        bit is_signed = (op == OP_DIV_L) || (op == OP_MOD_L);
        if (b == 0) begin
            q = '1; r = a;
        end else if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 0;
        end else if (is_signed) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return (op == OP_MOD_L || op == OP_UMOD_L) ? r : q;
    endfunction

    // Applies one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        int          op = int'(op_i);
        bit [DW-1:0] a = regA_i, b = regB_i, imm = operand_i;
        longint unsigned prod;
        m_we = 0;
        m_dz = 0;
        if (m_pending) begin
            if (m_left > 1) m_left--;
            else if (!stall_i) begin
                m_we = 1; m_dz = m_div_dz; m_res = m_div_res; m_idx = m_div_rd; m_pending = 0;
            end
        end else if (valid_i && !stall_i) begin
            m_we = 1;
            case (op)
                OP_ADD_L: m_res = a + b;
                OP_SUB_L: m_res = a - b;
                OP_AND:   m_res = a & b;
                OP_OR:    m_res = a | b;
                OP_XOR:   m_res = a ^ b;
                OP_NOT:   m_res = ~b;
                OP_NEG:   m_res = 0 - b;
                OP_ASHL:  m_res = a << (b % 32);
                OP_LSHR:  m_res = a >> (b % 32);
                OP_ASHR:  m_res = $signed(a) >>> (b % 32);
                OP_INC:   m_res = a + imm;
                OP_DEC:   m_res = a - imm;
                OP_LDI_L: m_res = imm;
                OP_MOV:   m_res = b;
                OP_MUL_L: begin prod = longint'(a) * longint'(b); m_res = prod[31:0]; end
                OP_CMP: begin
                    m_we = 0;
                    m_flags = {a > b, $signed(a) > $signed(b), a < b, $signed(a) < $signed(b), a == b};
                end
                OP_DIV_L, OP_UDIV_L, OP_MOD_L, OP_UMOD_L: begin
                    m_we = 0;
                    m_pending = 1;
                    m_left = DW + 1;
                    m_div_res = ref_div(op, a, b);
                    m_div_dz = (b == 0);
                    m_div_rd = register_write_index_i;
                end
                default: m_we = 0;
            endcase
            if (m_we) m_idx = register_write_index_i;
        end
    endtask

    task automatic compare_all();
        check("busy", busy_o, stall_i | m_pending);
        check("we", register_write_enable_o, m_we);
        check("idx", register_write_index_o, m_idx);
        check("result", result_o, m_res);
        check("flags", flags_o, m_flags);
        check("div_zero", div_zero_o, m_dz);
    endtask

    task automatic step();
        @(negedge clk_i);
        compare_all();
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input bit v, input bit s, input int op, input bit [DW-1:0] a,
                         input bit [DW-1:0] b, input bit [DW-1:0] imm, input bit [3:0] rd);
        valid_i = v; stall_i = s; op_i = 6'(op);
        regA_i = a; regB_i = b; operand_i = imm; register_write_index_i = rd;
    endtask

    task automatic idle(input int n);
        valid_i = 0; stall_i = 0; op_i = 6'(OP_NOP);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic bit [DW-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ops_tab[21] = '{OP_NOP, OP_ADD_L, OP_SUB_L, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NEG,
                            OP_ASHL, OP_LSHR, OP_ASHR, OP_INC, OP_DEC, OP_LDI_L, OP_MOV,
                            OP_MUL_L, OP_CMP, OP_DIV_L, OP_UDIV_L, OP_MOD_L, OP_UMOD_L};
        rst_i = 1;
        drive(0, 0, OP_NOP, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk_i);
        #1 rst_i = 0;
        check("reset_we", register_write_enable_o, 0);
        check("reset_result", result_o, 0);
        check("reset_flags", flags_o, 0);
        check("reset_busy", busy_o, 0);

        drive(1, 0, OP_ADD_L, 32'hFFFF_FFFF, 2, 0, 4'd3); step();
        check("add_we", register_write_enable_o, 1);
        check("add_result", result_o, 32'h1);
        check("add_idx", register_write_index_o, 4'd3);
        drive(1, 0, OP_ASHR, 32'h8000_0000, 4, 0, 4'd4); step();
        check("ashr_result", result_o, 32'hF800_0000);
        drive(1, 0, OP_LDI_L, 0, 0, 32'h1234_5678, 4'd6); step();
        check("ldi_result", result_o, 32'h1234_5678);
        idle(1);
        check("we_one_cycle", register_write_enable_o, 0);

        drive(1, 0, OP_CMP, 32'hFFFF_FFFF, 1, 0, 4'd2); step();
        check("cmp_flags", flags_o, 5'b10010);
        check("cmp_no_we", register_write_enable_o, 0);
        drive(1, 0, OP_NOP, 0, 0, 0, 0); step();
        check("nop_flags_hold", flags_o, 5'b10010);

        drive(1, 0, OP_DIV_L, -32'sd7, 2, 0, 4'd5); step();
        check("div_busy_first", busy_o, 1);
        idle(DW);
        check("div_busy_last", busy_o, 1);
        check("div_no_early_we", register_write_enable_o, 0);
        idle(1);
        check("div_we", register_write_enable_o, 1);
        check("div_result", result_o, 32'hFFFF_FFFD);
        check("div_idx", register_write_index_o, 4'd5);
        check("div_busy_clear", busy_o, 0);

        drive(1, 0, OP_MOD_L, -32'sd7, 2, 0, 4'd6); step(); idle(DW + 1);
        check("mod_result", result_o, 32'hFFFF_FFFF);
        drive(1, 0, OP_UDIV_L, 5, 0, 0, 4'd7); step(); idle(DW + 1);
        check("udiv0_result", result_o, 32'hFFFF_FFFF);
        check("udiv0_dz", div_zero_o, 1);
        idle(1);
        check("dz_one_cycle", div_zero_o, 0);
        drive(1, 0, OP_DIV_L, 32'h8000_0000, 32'hFFFF_FFFF, 0, 4'd8); step(); idle(DW + 1);
        check("ovf_result", result_o, 32'h8000_0000);
        check("ovf_no_dz", div_zero_o, 0);

        // Stall from cycle 30 to 40 of a divide, with an ADD offered meanwhile.
        drive(1, 0, OP_DIV_L, 100, -32'sd7, 0, 4'd9); step();
        idle(29);
        drive(1, 1, OP_ADD_L, 1, 1, 0, 4'd12);
        for (int i = 0; i < 10; i++) step();
        check("stall_no_we", register_write_enable_o, 0);
        drive(0, 0, OP_NOP, 0, 0, 0, 0); step();
        check("stall_div_we", register_write_enable_o, 1);
        check("stall_div_result", result_o, 32'hFFFF_FFF2);
        check("stall_div_idx", register_write_index_o, 4'd9);
        idle(1);
        check("stalled_add_dropped", register_write_enable_o, 0);

        // Reset in the middle of a divide.
        drive(1, 0, OP_ADD_L, 20, 22, 0, 4'd11); step();
        drive(1, 0, OP_UDIV_L, 100, 7, 0, 4'd10); step();
        idle(4);
        #2 rst_i = 1;
        #1;
        check("rst_mid_result", result_o, 0);
        check("rst_mid_idx", register_write_index_o, 0);
        check("rst_mid_flags", flags_o, 0);
        check("rst_mid_we", register_write_enable_o, 0);
        model_reset();
        @(posedge clk_i);
        #1 rst_i = 0;
        idle(DW + 4);
        drive(1, 0, OP_ADD_L, 40, 2, 0, 4'd1);
        check("post_rst_busy", busy_o, 0);
        step();
        check("post_rst_add", result_o, 32'd42);

        for (int c = 0; c < 3000; c++) begin
            int op;
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(21, 63))
                                              : ops_tab[$urandom_range(0, 20)];
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) < 3, op,
                  rnd_val(), rnd_val(), rnd_val(), 4'($urandom_range(0, 15)));
            step();
        end
        idle(DW + 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
